// File: rtl/mux_arb_defs.sv
// Shared constants for the 3-to-1 mux arbiter: state codes, select codes,
// the default hold limit and the round-robin successor helper.
package mux_arb_defs;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [1:0] SEL_IN0 = 2'b00;
  localparam logic [1:0] SEL_IN1 = 2'b01;
  localparam logic [1:0] SEL_IN2 = 2'b10;

  localparam int MAX_HOLD_DEFAULT = 8;

  // Last winner after reset is requester 2, so requester 0 is searched first.
  localparam logic [1:0] LAST_RESET = SEL_IN2;

  // Next requester index in the cyclic order 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == SEL_IN2) ? SEL_IN0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin pick among three requesters. The search starts
// at the requester after the last winner and wraps; gnt is one-hot (or zero
// when nobody requests) and idx is the matching 2-bit mux select code.
module rr_pick3
  import mux_arb_defs::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] gnt,
  output logic [1:0] idx
);

  logic [3:0] req_ext;
  logic [1:0] cand;
  logic       found;

  // Walk the three candidates in round-robin order, keep the first requester.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    req_ext = {1'b0, req};
    gnt     = 3'b000;
    idx     = SEL_IN0;
    found   = 1'b0;
    cand    = rr_next(last);
    for (int k = 0; k < 3; k++) begin
      if (!found && req_ext[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = rr_next(cand);
    end
    if (found) begin
      gnt = 3'b001 << idx;
    end
  end

endmodule

// File: rtl/mux_3to1_arbiter.sv
// Round-robin arbiter steering a 3-to-1 mux. A grant lasts while its
// requester keeps asking, up to MAX_HOLD cycles, and every grant is followed
// by one IDLE cycle so the mux select only moves while nothing is routed
// (break-before-make). All outputs come straight from flops.
module mux_3to1_arbiter
  import mux_arb_defs::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT  // legal 1..15
) (
  input  logic       Clock,
  input  logic       _Reset,
  input  logic [2:0] Req,
  output logic [2:0] Grant,
  output logic [1:0] Select,
  output logic [1:0] _Select,
  output logic       Busy
);

  logic [0:0] state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] sel_q,   sel_d;
  logic [1:0] nsel_q,  nsel_d;
  logic       busy_q,  busy_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [1:0] last_q,  last_d;

  logic [2:0] pick_gnt;
  logic [1:0] pick_idx;
  logic       owner_req;
  logic       hold_done;

  rr_pick3 u_pick (
    .req  (Req),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  // The current owner is still asking only if its own request bit is set;
  // other requesters' bits are ignored while a grant is held.
  assign owner_req = |(Req & grant_q);
  assign hold_done = (cnt_q == 4'(MAX_HOLD));

  // Next-state logic: arbitrate from IDLE, release from GRANT on drop or limit.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (|Req) begin
          state_d = ST_GRANT;
          grant_d = pick_gnt;
          sel_d   = pick_idx;
          last_d  = pick_idx;
          cnt_d   = 4'd1;
        end
      end
      ST_GRANT: begin
        if (!owner_req || hold_done) begin
          state_d = ST_IDLE;
          grant_d = 3'b000;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 3'b000;
        cnt_d   = 4'd0;
      end
    endcase
    // Complement rail and Busy are their own flops, so they are registered too.
    nsel_d = ~sel_d;
    busy_d = |grant_d;
  end

  // State and output registers; reset parks the mux on In0 with Last = 2.
  always_ff @(posedge Clock or negedge _Reset) begin
    if (!_Reset) begin
      state_q <= ST_IDLE;
      grant_q <= 3'b000;
      sel_q   <= SEL_IN0;
      nsel_q  <= ~SEL_IN0;
      busy_q  <= 1'b0;
      cnt_q   <= 4'd0;
      last_q  <= LAST_RESET;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      nsel_q  <= nsel_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign Grant   = grant_q;
  assign Select  = sel_q;
  assign _Select = nsel_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_mux_3to1_arbiter.sv
// Self-checking bench for mux_3to1_arbiter: directed scenarios plus a
// randomized run against a behavioural owner/hold-count reference model.
module tb_mux_3to1_arbiter;

  localparam int HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] grant;
  logic [1:0] sel;
  logic [1:0] nsel;
  logic       busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: who owns the mux (-1 = nobody), for how many cycles,
  // who won last, and where the mux is parked.
  int m_owner;
  int m_held;
  int m_last;
  int m_sel;

  mux_3to1_arbiter #(.MAX_HOLD(HOLD)) dut (
    .Clock   (clk),
    ._Reset  (rst_n),
    .Req     (req),
    .Grant   (grant),
    .Select  (sel),
    ._Select (nsel),
    .Busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Structural invariants, sampled on the falling edge every cycle.
  always @(negedge clk) begin
    n_compared++;
    if (nsel !== ~sel) begin
      n_mismatched++;
      $display("FAIL inv_rails: Select %b _Select %b, required _Select %b", sel, nsel, ~sel);
    end
    n_compared++;
    if (sel === 2'b11 || $isunknown(sel)) begin
      n_mismatched++;
      $display("FAIL inv_sel_code: Select %b, required one of 00/01/10", sel);
    end
    n_compared++;
    if (!$onehot0(grant) || $isunknown(grant)) begin
      n_mismatched++;
      $display("FAIL inv_onehot: Grant %b, required one-hot or zero", grant);
    end
    n_compared++;
    if (busy !== (|grant)) begin
      n_mismatched++;
      $display("FAIL inv_busy: Busy %b with Grant %b", busy, grant);
    end
  end

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 2;
    m_sel   = 0;
  endtask

  // Advance the model by one clock using the request vector seen at the edge.
  task automatic model_step(input logic [2:0] r);
    int c;
    if (m_owner < 0) begin
      for (int k = 1; k <= 3; k++) begin
        c = (m_last + k) % 3;
        if (r[c]) begin
          m_owner = c;
          m_last  = c;
          m_sel   = c;
          m_held  = 1;
          break;
        end
      end
    end else if (!r[m_owner] || m_held == HOLD) begin
      m_owner = -1;
      m_held  = 0;
    end else begin
      m_held++;
    end
  endtask

  function automatic logic [2:0] exp_grant();
    return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
  endfunction

  function automatic logic [1:0] exp_sel();
    return 2'(m_sel);
  endfunction

  // Drive one request vector for one clock and advance the model with it.
  task automatic step(input logic [2:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic reset_pulse();
    req = 3'b000;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    req   = 3'b111;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    n_compared++;
    if (grant !== 3'b000 || busy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_grant: Grant %b Busy %b, required 000 0", grant, busy);
    end
    n_compared++;
    if (sel !== 2'b00 || nsel !== 2'b11) begin
      n_mismatched++;
      $display("FAIL reset_sel: Select %b _Select %b, required 00 11", sel, nsel);
    end
    // Requests while reset is held must not be granted.
    repeat (2) @(posedge clk);
    #1;
    n_compared++;
    if (grant !== 3'b000) begin
      n_mismatched++;
      $display("FAIL reset_hold: Grant %b, required 000", grant);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b111);
    n_compared++;
    if (grant !== 3'b001 || sel !== 2'b00) begin
      n_mismatched++;
      $display("FAIL reset_first_grant: Grant %b Select %b, required 001 00", grant, sel);
    end
    step(3'b111);
    step(3'b111);
    step(3'b111);
    // Jump forward to the second grant so the mid-grant reset hits In1.
    repeat (6) step(3'b111);
    n_compared++;
    if (grant !== 3'b010) begin
      n_mismatched++;
      $display("FAIL reset_pre: Grant %b, required 010", grant);
    end
    #2 rst_n = 1'b0;
    #1;
    n_compared++;
    if (grant !== 3'b000 || busy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_async_grant: Grant %b Busy %b, required 000 0", grant, busy);
    end
    n_compared++;
    if (sel !== 2'b00 || nsel !== 2'b11) begin
      n_mismatched++;
      $display("FAIL reset_async_sel: Select %b _Select %b, required 00 11", sel, nsel);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b111);
    n_compared++;
    if (grant !== 3'b001) begin
      n_mismatched++;
      $display("FAIL reset_regrant: Grant %b, required 001", grant);
    end
  endtask

  task automatic test_single();
    logic [2:0] want;
    step(3'b000);
    step(3'b000);
    for (int i = 0; i < 20; i++) begin
      step(3'b010);
      want = ((i % (HOLD + 1)) < HOLD) ? 3'b010 : 3'b000;
      n_compared++;
      if (grant !== want) begin
        n_mismatched++;
        $display("FAIL single_grant cyc %0d: Grant %b, required %b", i, grant, want);
      end
      n_compared++;
      if (sel !== 2'b01 || nsel !== 2'b10) begin
        n_mismatched++;
        $display("FAIL single_sel cyc %0d: Select %b _Select %b, required 01 10", i, sel, nsel);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] want;
    logic [1:0] want_sel;
    reset_pulse();
    for (int i = 0; i < 4 * (HOLD + 1); i++) begin
      step(3'b111);
      want_sel = 2'((i / (HOLD + 1)) % 3);
      want     = ((i % (HOLD + 1)) < HOLD) ? 3'(1 << want_sel) : 3'b000;
      n_compared++;
      if (grant !== want) begin
        n_mismatched++;
        $display("FAIL rr_grant cyc %0d: Grant %b, required %b", i, grant, want);
      end
      n_compared++;
      if (sel !== want_sel) begin
        n_mismatched++;
        $display("FAIL rr_sel cyc %0d: Select %b, required %b", i, sel, want_sel);
      end
    end
  endtask

  task automatic test_early_release();
    step(3'b000);
    step(3'b000);
    for (int i = 0; i < 3; i++) begin
      step(3'b100);
      n_compared++;
      if (grant !== 3'b100) begin
        n_mismatched++;
        $display("FAIL early_grant cyc %0d: Grant %b, required 100", i, grant);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(3'b000);
      n_compared++;
      if (grant !== 3'b000 || busy !== 1'b0 || sel !== 2'b10) begin
        n_mismatched++;
        $display("FAIL early_idle cyc %0d: Grant %b Busy %b Select %b, required 000 0 10",
                 i, grant, busy, sel);
      end
    end
  endtask

  task automatic test_contention();
    step(3'b000);
    step(3'b000);
    step(3'b010);
    step(3'b010);
    step(3'b010);
    for (int i = 0; i < 3; i++) begin
      step(3'b011);
      n_compared++;
      if (grant !== 3'b010 || sel !== 2'b01) begin
        n_mismatched++;
        $display("FAIL contend_hold cyc %0d: Grant %b Select %b, required 010 01", i, grant, sel);
      end
    end
    step(3'b001);
    n_compared++;
    if (grant !== 3'b000 || sel !== 2'b01) begin
      n_mismatched++;
      $display("FAIL contend_gap: Grant %b Select %b, required 000 01", grant, sel);
    end
    step(3'b001);
    n_compared++;
    if (grant !== 3'b001 || sel !== 2'b00) begin
      n_mismatched++;
      $display("FAIL contend_switch: Grant %b Select %b, required 001 00", grant, sel);
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    r = 3'b000;
    for (int i = 0; i < 400; i++) begin
      // Mostly keep the previous vector so long holds and limits occur.
      if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
      step(r);
      n_compared++;
      if (grant !== exp_grant() || sel !== exp_sel() || busy !== (m_owner >= 0)) begin
        n_mismatched++;
        $display("FAIL random cyc %0d req %b: Grant %b Select %b Busy %b, required %b %b %b",
                 i, r, grant, sel, busy, exp_grant(), exp_sel(), (m_owner >= 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_contention();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
